// File: rtl/npc_btb_predictor.sv
// Fetch-stage next-PC unit: holds the fetch PC and predicts the next one from a
// direct-mapped BTB of 2-bit counters trained by resolved branches and jumps.
module npc_btb_predictor #(
  parameter int               ADDR_W    = 32,
  parameter int               BTB_DEPTH = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hBFC0_0000),
  parameter logic [1:0]       CTR_ALLOC = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              res_valid_i,
  input  logic [1:0]        res_type_i,
  input  logic [ADDR_W-1:0] res_pc_i,
  input  logic              res_taken_i,
  input  logic [ADDR_W-1:0] res_target_i,
  input  logic              res_pred_taken_i,
  input  logic [ADDR_W-1:0] res_pred_target_i,
  output logic              flush_o,
  output logic [31:0]       mispred_cnt_o
);

  localparam int IDX_W = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [1:0] T_BR = 2'd0;
  localparam logic [1:0] T_J  = 2'd1;
  localparam logic [1:0] T_JR = 2'd2;

  // Resolution port: res_valid_i marks exactly one resolved instruction in the
  // cycle it is high; there is no ready, every resolution is consumed that cycle.

  logic [ADDR_W-1:0]    pc;
  logic [31:0]          mispred_cnt;
  logic [BTB_DEPTH-1:0] valid;
  logic [BTB_DEPTH-1:0] is_jump;
  logic [TAG_W-1:0]     tag_mem [BTB_DEPTH];
  logic [ADDR_W-1:0]    tgt_mem [BTB_DEPTH];
  logic [1:0]           ctr_mem [BTB_DEPTH];

  logic [IDX_W-1:0]  fetch_idx;
  logic [TAG_W-1:0]  fetch_tag;
  logic              fetch_hit;
  logic [ADDR_W-1:0] pc_plus4;

  logic [IDX_W-1:0]  res_idx;
  logic [TAG_W-1:0]  res_tag;
  logic              res_hit;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;

  assign fetch_idx = pc[IDX_W+1:2];
  assign fetch_tag = pc[ADDR_W-1:IDX_W+2];
  assign fetch_hit = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);
  assign pc_plus4  = pc + ADDR_W'(4);

  assign pred_taken_o  = fetch_hit && (is_jump[fetch_idx] || ctr_mem[fetch_idx][1]);
  assign pred_target_o = pred_taken_o ? tgt_mem[fetch_idx] : pc_plus4;

  assign res_idx = res_pc_i[IDX_W+1:2];
  assign res_tag = res_pc_i[ADDR_W-1:IDX_W+2];
  assign res_hit = valid[res_idx] && (tag_mem[res_idx] == res_tag);

  // A correct not-taken prediction is fine whatever target travelled with it.
  assign mispredict = res_valid_i && (res_type_i != 2'd3) &&
                      ((res_taken_i != res_pred_taken_i) ||
                       (res_taken_i && (res_target_i != res_pred_target_i)));
  assign redirect_pc = res_taken_i ? res_target_i : (res_pc_i + ADDR_W'(4));

  assign flush_o       = mispredict;
  assign pc_o          = pc;
  assign mispred_cnt_o = mispred_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      mispred_cnt <= '0;
      valid       <= '0;
    end else begin
      if (mispredict) begin
        pc <= redirect_pc;
      end else if (!stall_i) begin
        pc <= pred_target_o;
      end
      if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
      if (res_valid_i) begin
        case (res_type_i)
          T_BR:    if (res_taken_i && !res_hit) valid[res_idx] <= 1'b1;
          T_J:     valid[res_idx] <= 1'b1;
          T_JR:    if (res_hit) valid[res_idx] <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Entry payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (res_valid_i) begin
      case (res_type_i)
        T_BR: begin
          if (res_taken_i) begin
            if (res_hit) begin
              if (ctr_mem[res_idx] != 2'd3) ctr_mem[res_idx] <= ctr_mem[res_idx] + 2'd1;
              tgt_mem[res_idx] <= res_target_i;
            end else begin
              tag_mem[res_idx] <= res_tag;
              tgt_mem[res_idx] <= res_target_i;
              ctr_mem[res_idx] <= CTR_ALLOC;
              is_jump[res_idx] <= 1'b0;
            end
          end else if (res_hit && (ctr_mem[res_idx] != 2'd0)) begin
            ctr_mem[res_idx] <= ctr_mem[res_idx] - 2'd1;
          end
        end
        T_J: begin
          tag_mem[res_idx] <= res_tag;
          tgt_mem[res_idx] <= res_target_i;
          ctr_mem[res_idx] <= 2'd3;
          is_jump[res_idx] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_btb_predictor.sv
// Directed bench for npc_btb_predictor: the driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_npc_btb_predictor;

  localparam int W = 98;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [1:0]  res_type;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic        flush;
  logic [31:0] mispred_cnt;

  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  npc_btb_predictor dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall),
    .pc_o              (pc),
    .pred_taken_o      (pred_taken),
    .pred_target_o     (pred_target),
    .res_valid_i       (res_valid),
    .res_type_i        (res_type),
    .res_pc_i          (res_pc),
    .res_taken_i       (res_taken),
    .res_target_i      (res_target),
    .res_pred_taken_i  (res_pred_taken),
    .res_pred_target_i (res_pred_target),
    .flush_o           (flush),
    .mispred_cnt_o     (mispred_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic st, input logic rv, input logic [1:0] ty,
                       input logic [31:0] rpc, input logic tk, input logic [31:0] tg,
                       input logic ppt, input logic [31:0] ptg);
    stall = st; res_valid = rv; res_type = ty; res_pc = rpc;
    res_taken = tk; res_target = tg; res_pred_taken = ppt; res_pred_target = ptg;
  endtask

  task automatic idle(input logic st);
    drive(st, 1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Not-taken branch that was predicted taken: forces fetch to rpc+4.
  task automatic nt_redirect(input logic [31:0] rpc);
    drive(1'b0, 1'b1, 2'd0, rpc, 1'b0, 32'h0, 1'b1, 32'h0);
  endtask

  task automatic expect_out(input logic [31:0] e_pc, input logic e_pt, input logic [31:0] e_ptg,
                            input logic e_fl, input logic [31:0] e_cnt);
    exp_q.push_back({e_pc, e_pt, e_ptg, e_fl, e_cnt});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      cmp("pc",          pc,                   e[97:66]);
      cmp("pred_taken",  {31'd0, pred_taken},  {31'd0, e[65]});
      cmp("pred_target", pred_target,          e[64:33]);
      cmp("flush",       {31'd0, flush},       {31'd0, e[32]});
      cmp("mispred_cnt", mispred_cnt,          e[31:0]);
    end
  end

  initial begin
    rst = 1'b1;
    idle(1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Free-running fetch out of reset
    expect_out(32'hBFC0_0000, 0, 32'hBFC0_0004, 0, 0); tick();
    expect_out(32'hBFC0_0004, 0, 32'hBFC0_0008, 0, 0); tick();
    expect_out(32'hBFC0_0008, 0, 32'hBFC0_000C, 0, 0); tick();

    // Taken branch mispredict allocates the entry
    drive(0, 1, 2'd0, 32'hBFC0_0010, 1, 32'hBFC0_0100, 0, 32'hBFC0_0014);
    expect_out(32'hBFC0_000C, 0, 32'hBFC0_0010, 1, 0); tick();
    idle(0);                   expect_out(32'hBFC0_0100, 0, 32'hBFC0_0104, 0, 1); tick();
    nt_redirect(32'hBFC0_000C); expect_out(32'hBFC0_0104, 0, 32'hBFC0_0108, 1, 1); tick();
    idle(0);                   expect_out(32'hBFC0_0010, 1, 32'hBFC0_0100, 0, 2); tick();

    // Train the counter down 2 -> 1 -> 0, then back up to 1
    drive(0, 1, 2'd0, 32'hBFC0_0010, 0, 32'h0, 1, 32'hBFC0_0100);
    expect_out(32'hBFC0_0100, 0, 32'hBFC0_0104, 1, 2); tick();
    nt_redirect(32'hBFC0_000C); expect_out(32'hBFC0_0014, 0, 32'hBFC0_0018, 1, 3); tick();
    drive(0, 1, 2'd0, 32'hBFC0_0010, 0, 32'h0, 1, 32'hBFC0_0100);
    expect_out(32'hBFC0_0010, 0, 32'hBFC0_0014, 1, 4); tick();
    nt_redirect(32'hBFC0_000C); expect_out(32'hBFC0_0014, 0, 32'hBFC0_0018, 1, 5); tick();
    drive(0, 1, 2'd0, 32'hBFC0_0010, 1, 32'hBFC0_0100, 0, 32'hBFC0_0014);
    expect_out(32'hBFC0_0010, 0, 32'hBFC0_0014, 1, 6); tick();
    nt_redirect(32'hBFC0_000C); expect_out(32'hBFC0_0100, 0, 32'hBFC0_0104, 1, 7); tick();
    drive(0, 1, 2'd0, 32'hBFC0_0010, 0, 32'h0, 0, 32'hBFC0_0014);
    expect_out(32'hBFC0_0010, 0, 32'hBFC0_0014, 0, 8); tick();
    idle(0);                   expect_out(32'hBFC0_0014, 0, 32'hBFC0_0018, 0, 8); tick();

    // Stall with a direct-jump mispredict, then stall alone for 3 cycles
    drive(1, 1, 2'd1, 32'hBFC0_0030, 1, 32'hBFC0_0200, 0, 32'hBFC0_0034);
    expect_out(32'hBFC0_0018, 0, 32'hBFC0_001C, 1, 8); tick();
    for (int i = 0; i < 3; i++) begin
      idle(1); expect_out(32'hBFC0_0200, 0, 32'hBFC0_0204, 0, 9); tick();
    end
    idle(0);                   expect_out(32'hBFC0_0200, 0, 32'hBFC0_0204, 0, 9); tick();
    nt_redirect(32'hBFC0_002C); expect_out(32'hBFC0_0204, 0, 32'hBFC0_0208, 1, 9); tick();
    idle(0);                   expect_out(32'hBFC0_0030, 1, 32'hBFC0_0200, 0, 10); tick();

    // Register jump: redirect without allocation, then invalidation of a hit
    drive(0, 1, 2'd2, 32'hBFC0_0020, 1, 32'h8000_0000, 0, 32'hBFC0_0024);
    expect_out(32'hBFC0_0200, 0, 32'hBFC0_0204, 1, 10); tick();
    nt_redirect(32'hBFC0_001C); expect_out(32'h8000_0000, 0, 32'h8000_0004, 1, 11); tick();
    idle(0);                   expect_out(32'hBFC0_0020, 0, 32'hBFC0_0024, 0, 12); tick();
    drive(0, 1, 2'd2, 32'hBFC0_0030, 1, 32'hBFC0_0200, 1, 32'hBFC0_0200);
    expect_out(32'hBFC0_0024, 0, 32'hBFC0_0028, 0, 12); tick();
    nt_redirect(32'hBFC0_002C); expect_out(32'hBFC0_0028, 0, 32'hBFC0_002C, 1, 12); tick();
    idle(0);                   expect_out(32'hBFC0_0030, 0, 32'hBFC0_0034, 0, 13); tick();

    // Aliasing on index 4 between 0xBFC00010 and 0xBFC00050
    nt_redirect(32'hBFC0_004C); expect_out(32'hBFC0_0034, 0, 32'hBFC0_0038, 1, 13); tick();
    drive(0, 1, 2'd0, 32'hBFC0_0050, 0, 32'h0, 0, 32'hBFC0_0054);
    expect_out(32'hBFC0_0050, 0, 32'hBFC0_0054, 0, 14); tick();
    nt_redirect(32'hBFC0_000C); expect_out(32'hBFC0_0054, 0, 32'hBFC0_0058, 1, 14); tick();
    drive(0, 1, 2'd0, 32'hBFC0_0050, 1, 32'hBFC0_0300, 0, 32'hBFC0_0054);
    expect_out(32'hBFC0_0010, 0, 32'hBFC0_0014, 1, 15); tick();
    nt_redirect(32'hBFC0_000C); expect_out(32'hBFC0_0300, 0, 32'hBFC0_0304, 1, 16); tick();
    nt_redirect(32'hBFC0_004C); expect_out(32'hBFC0_0010, 0, 32'hBFC0_0014, 1, 17); tick();
    idle(0);                   expect_out(32'hBFC0_0050, 1, 32'hBFC0_0300, 0, 18); tick();

    // Address wrap of +4 arithmetic, and reserved type
    nt_redirect(32'hFFFF_FFF8); expect_out(32'hBFC0_0300, 0, 32'hBFC0_0304, 1, 18); tick();
    idle(0);                   expect_out(32'hFFFF_FFFC, 0, 32'h0000_0000, 0, 19); tick();
    nt_redirect(32'hFFFF_FFFC); expect_out(32'h0000_0000, 0, 32'h0000_0004, 1, 19); tick();
    drive(0, 1, 2'd3, 32'h0000_0040, 1, 32'h0000_0800, 0, 32'h0000_0044);
    expect_out(32'h0000_0000, 0, 32'h0000_0004, 0, 20); tick();
    idle(0);                   expect_out(32'h0000_0004, 0, 32'h0000_0008, 0, 20); tick();

    // Counter saturation
    force dut.mispred_cnt = 32'hFFFF_FFFE;
    #1 release dut.mispred_cnt;
    nt_redirect(32'h0000_0020); expect_out(32'h0000_0008, 0, 32'h0000_000C, 1, 32'hFFFF_FFFE); tick();
    nt_redirect(32'h0000_0020); expect_out(32'h0000_0024, 0, 32'h0000_0028, 1, 32'hFFFF_FFFF); tick();
    idle(0);                   expect_out(32'h0000_0024, 0, 32'h0000_0028, 0, 32'hFFFF_FFFF); tick();

    // Asynchronous reset while a redirect is being presented
    drive(0, 1, 2'd0, 32'h0000_0028, 1, 32'h0000_1000, 0, 32'h0000_002C);
    #1 rst = 1'b1;
    expect_out(32'hBFC0_0000, 0, 32'hBFC0_0004, 1, 0);
    @(negedge clk);
    #1;
    idle(0);
    rst = 1'b0;
    tick();
    nt_redirect(32'hBFC0_004C); expect_out(32'hBFC0_0004, 0, 32'hBFC0_0008, 1, 0); tick();
    idle(0);                   expect_out(32'hBFC0_0050, 0, 32'hBFC0_0054, 0, 1); tick();

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
